// File: rtl/fwd_pkg.sv
// Shared types for the EX-stage operand bypass and load-use hazard unit.
// FWD_XLEN fixes the history data width; the unit's XLEN parameter must match it.
package fwd_pkg;

  localparam int unsigned FWD_XLEN = 32;

  typedef struct packed {
    logic                valid;
    logic [4:0]          rd;
    logic                is_load;
    logic [FWD_XLEN-1:0] data;
  } hist_entry_t;

  typedef enum logic [1:0] {
    SRC_RF,
    SRC_HIST,
    SRC_MEM,
    SRC_HAZARD
  } fwd_src_t;

  // x0 is hardwired to zero, so it never takes a bypassed value.
  function automatic logic src_matches(input hist_entry_t e, input logic [4:0] idx);
    return e.valid && (e.rd == idx) && (idx != 5'd0);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority search over the write history for one source operand.
// With FWD_BYPASS_STATS_EN defined it also reports whether the value came from the history.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic [4:0]                src_idx,
  input  logic [XLEN-1:0]           rf_data,
  input  hist_entry_t [DEPTH-1:0]   hist,
  input  logic [XLEN-1:0]           mem_rdata,
  output logic [XLEN-1:0]           value,
  output logic                      hazard
`ifdef FWD_BYPASS_STATS_EN
  ,
  output logic                      fwd_hit
`endif
);

  fwd_src_t src;

  // Walk from oldest to youngest so the youngest matching producer is written last and wins.
  always_comb begin
    src   = SRC_RF;
    value = rf_data;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (src_matches(hist[k], src_idx)) begin
        if (hist[k].is_load && (k < LOAD_LAT)) begin
          src   = SRC_HAZARD;
          value = rf_data;
        end else if (hist[k].is_load && (k == LOAD_LAT)) begin
          src   = SRC_MEM;
          value = mem_rdata;
        end else begin
          src   = SRC_HIST;
          value = XLEN'(hist[k].data);
        end
      end
    end
  end

  assign hazard = (src == SRC_HAZARD);

`ifdef FWD_BYPASS_STATS_EN
  assign fwd_hit = (src == SRC_HIST) || (src == SRC_MEM);
`endif

endmodule

// File: rtl/fwd_bypass_unit.sv
// EX-stage operand bypass, PC/immediate select and load-use stall over a DEPTH-entry write history.
// Optional FWD_BYPASS_STATS_EN adds forward/stall event counters.
module fwd_bypass_unit
  import fwd_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [4:0]      ex_rs1_idx,
  input  logic [4:0]      ex_rs2_idx,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            ex_a_pc_sel,
  input  logic            ex_b_imm_sel,
  input  logic            ex_we,
  input  logic [4:0]      ex_rd,
  input  logic            ex_is_load,
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            flush,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] br_a,
  output logic [XLEN-1:0] br_b,
  output logic            stall
`ifdef FWD_BYPASS_STATS_EN
  ,
  output logic [31:0]     stat_fwd_cnt,
  output logic [31:0]     stat_stall_cnt
`endif
);

  hist_entry_t [DEPTH-1:0] hist;
  hist_entry_t [DEPTH-1:0] hist_view;
  hist_entry_t [DEPTH-1:0] hist_nxt;

  logic [XLEN-1:0] byp_a;
  logic [XLEN-1:0] byp_b;
  logic            hazard_a;
  logic            hazard_b;

  // While reset is held the history is treated as empty, so outputs fall back to the register file.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      hist_view[k]       = hist[k];
      hist_view[k].valid = hist[k].valid & rst_n;
    end
  end

`ifdef FWD_BYPASS_STATS_EN
  logic fwd_hit_a;
  logic fwd_hit_b;
`endif

  fwd_match #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .LOAD_LAT (LOAD_LAT)
  ) u_match_rs1 (
    .src_idx   (ex_rs1_idx),
    .rf_data   (ex_rs1),
    .hist      (hist_view),
    .mem_rdata (mem_rdata),
    .value     (byp_a),
    .hazard    (hazard_a)
`ifdef FWD_BYPASS_STATS_EN
    ,
    .fwd_hit   (fwd_hit_a)
`endif
  );

  fwd_match #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .LOAD_LAT (LOAD_LAT)
  ) u_match_rs2 (
    .src_idx   (ex_rs2_idx),
    .rf_data   (ex_rs2),
    .hist      (hist_view),
    .mem_rdata (mem_rdata),
    .value     (byp_b),
    .hazard    (hazard_b)
`ifdef FWD_BYPASS_STATS_EN
    ,
    .fwd_hit   (fwd_hit_b)
`endif
  );

  assign stall = ex_valid && !flush && (hazard_a || hazard_b);

  assign op_a = ex_a_pc_sel  ? ex_pc  : byp_a;
  assign op_b = ex_b_imm_sel ? ex_imm : byp_b;
  assign br_a = byp_a;
  assign br_b = byp_b;

  // The history always advances; a stalled or flushed EX instruction enters as a bubble.
  // A load leaving H[LOAD_LAT] carries the memory data it was forwarding into H[LOAD_LAT+1].
  always_comb begin
    hist_nxt[0].valid   = ex_valid && ex_we && !stall && !flush;
    hist_nxt[0].rd      = ex_rd;
    hist_nxt[0].is_load = ex_is_load;
    hist_nxt[0].data    = FWD_XLEN'(ex_result);
    for (int k = 1; k < DEPTH; k++) begin
      hist_nxt[k] = hist[k-1];
      if ((k == LOAD_LAT + 1) && hist[k-1].valid && hist[k-1].is_load) begin
        hist_nxt[k].data = FWD_XLEN'(mem_rdata);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist <= '0;
    end else begin
      hist <= hist_nxt;
    end
  end

`ifdef FWD_BYPASS_STATS_EN
  // Forward events count only for instructions that actually proceed out of EX.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_fwd_cnt   <= 32'd0;
      stat_stall_cnt <= 32'd0;
    end else begin
      if (stall) begin
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
      end
      if (ex_valid && !flush && !stall && (fwd_hit_a || fwd_hit_b)) begin
        stat_fwd_cnt <= stat_fwd_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwd_bypass_unit.sv
// Scoreboard bench for fwd_bypass_unit: directed hazard scenarios followed by random traffic,
// checked against a queue-based history model. Stats counters are checked when FWD_BYPASS_STATS_EN is defined.
module tb_fwd_bypass_unit;

  localparam int XLEN     = 32;
  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 1;

  typedef struct packed {
    logic        valid;
    logic        flush;
    logic        rst_n;
    logic        we;
    logic        ld;
    logic        asel;
    logic        bsel;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rf1;
    logic [31:0] rf2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] res;
    logic [31:0] mrd;
  } stim_t;

  typedef struct packed {
    logic        stall;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] br_a;
    logic [31:0] br_b;
    logic        stats_zero;
  } exp_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        is_load;
    logic [31:0] data;
  } rec_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ex_valid = 1'b0;
  logic [4:0]      ex_rs1_idx = '0;
  logic [4:0]      ex_rs2_idx = '0;
  logic [XLEN-1:0] ex_rs1 = '0;
  logic [XLEN-1:0] ex_rs2 = '0;
  logic [XLEN-1:0] ex_pc = '0;
  logic [XLEN-1:0] ex_imm = '0;
  logic            ex_a_pc_sel = 1'b0;
  logic            ex_b_imm_sel = 1'b0;
  logic            ex_we = 1'b0;
  logic [4:0]      ex_rd = '0;
  logic            ex_is_load = 1'b0;
  logic [XLEN-1:0] ex_result = '0;
  logic [XLEN-1:0] mem_rdata = '0;
  logic            flush = 1'b0;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] br_a;
  logic [XLEN-1:0] br_b;
  logic            stall;
`ifdef FWD_BYPASS_STATS_EN
  logic [31:0]     stat_fwd_cnt;
  logic [31:0]     stat_stall_cnt;
`endif

  fwd_bypass_unit #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .LOAD_LAT (LOAD_LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_rs1_idx   (ex_rs1_idx),
    .ex_rs2_idx   (ex_rs2_idx),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .ex_pc        (ex_pc),
    .ex_imm       (ex_imm),
    .ex_a_pc_sel  (ex_a_pc_sel),
    .ex_b_imm_sel (ex_b_imm_sel),
    .ex_we        (ex_we),
    .ex_rd        (ex_rd),
    .ex_is_load   (ex_is_load),
    .ex_result    (ex_result),
    .mem_rdata    (mem_rdata),
    .flush        (flush),
    .op_a         (op_a),
    .op_b         (op_b),
    .br_a         (br_a),
    .br_b         (br_b),
    .stall        (stall)
`ifdef FWD_BYPASS_STATS_EN
    ,
    .stat_fwd_cnt   (stat_fwd_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  exp_t  exp_q[$];
  rec_t  mdl[$];
  stim_t cur;
  logic  cur_stall = 1'b0;
  logic  have_cur  = 1'b0;

  // Youngest write to a nonzero register wins; a load younger than LOAD_LAT has no data yet.
  function automatic void resolve(input logic [4:0] s, input logic [31:0] rf, input logic [31:0] mrd,
                                  input logic live, output logic [31:0] v, output logic hz);
    v  = rf;
    hz = 1'b0;
    if (live && s != 5'd0) begin
      for (int i = 0; i < mdl.size(); i++) begin
        if (mdl[i].valid && mdl[i].rd == s) begin
          if (mdl[i].is_load && i < LOAD_LAT) hz = 1'b1;
          else if (mdl[i].is_load && i == LOAD_LAT) v = mrd;
          else v = mdl[i].data;
          break;
        end
      end
    end
  endfunction

  task automatic model_reset();
    mdl.delete();
    for (int i = 0; i < DEPTH; i++) mdl.push_back('0);
  endtask

  task automatic model_advance();
    rec_t e;
    if (!cur.rst_n) begin
      model_reset();
    end else begin
      if (mdl[LOAD_LAT].valid && mdl[LOAD_LAT].is_load) mdl[LOAD_LAT].data = cur.mrd;
      e.valid   = cur.valid && cur.we && !cur_stall && !cur.flush;
      e.rd      = cur.rd;
      e.is_load = cur.ld;
      e.data    = cur.res;
      mdl.push_front(e);
      void'(mdl.pop_back());
    end
  endtask

  function automatic stim_t base();
    stim_t s;
    s       = '0;
    s.valid = 1'b1;
    s.rst_n = 1'b1;
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s, input logic stats_zero);
    exp_t        e;
    logic [31:0] v1, v2;
    logic        h1, h2;
    @(posedge clk);
    if (have_cur) model_advance();
    #1;
    ex_valid     = s.valid;
    flush        = s.flush;
    rst_n        = s.rst_n;
    ex_we        = s.we;
    ex_is_load   = s.ld;
    ex_a_pc_sel  = s.asel;
    ex_b_imm_sel = s.bsel;
    ex_rs1_idx   = s.rs1;
    ex_rs2_idx   = s.rs2;
    ex_rd        = s.rd;
    ex_rs1       = s.rf1;
    ex_rs2       = s.rf2;
    ex_pc        = s.pc;
    ex_imm       = s.imm;
    ex_result    = s.res;
    mem_rdata    = s.mrd;
    resolve(s.rs1, s.rf1, s.mrd, s.rst_n, v1, h1);
    resolve(s.rs2, s.rf2, s.mrd, s.rst_n, v2, h2);
    e.stall      = s.valid && !s.flush && (h1 || h2);
    e.op_a       = s.asel ? s.pc : v1;
    e.op_b       = s.bsel ? s.imm : v2;
    e.br_a       = v1;
    e.br_b       = v2;
    e.stats_zero = stats_zero;
    cur       = s;
    cur_stall = e.stall;
    have_cur  = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("stall", {31'd0, stall}, {31'd0, e.stall});
    cmp("op_a", op_a, e.op_a);
    cmp("op_b", op_b, e.op_b);
    cmp("br_a", br_a, e.br_a);
    cmp("br_b", br_b, e.br_b);
`ifdef FWD_BYPASS_STATS_EN
    if (e.stats_zero) begin
      cmp("stat_fwd_cnt", stat_fwd_cnt, 32'd0);
      cmp("stat_stall_cnt", stat_stall_cnt, 32'd0);
    end
`endif
  endtask

  // Monitor: outputs are combinational, so each cycle's response is taken mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    stim_t s;
    model_reset();

    s = '0;
    applyStimulus(s, 1'b0);
    applyStimulus(s, 1'b0);

    // addi x5 = 7, then two readers of x5 with rf x5 = 0
    s = base(); s.we = 1'b1; s.rd = 5'd5; s.res = 32'd7;
    applyStimulus(s, 1'b0);
    s = base(); s.rs1 = 5'd5; s.rs2 = 5'd5; s.rf1 = 32'd0; s.rf2 = 32'd0;
    applyStimulus(s, 1'b0);
    applyStimulus(s, 1'b0);

    // load x6, dependent add x7,x6,x6 held through the stall, then a late reader of x6
    s = base(); s.we = 1'b1; s.ld = 1'b1; s.rd = 5'd6; s.res = 32'hdead;
    applyStimulus(s, 1'b0);
    s = base(); s.rs1 = 5'd6; s.rs2 = 5'd6; s.we = 1'b1; s.rd = 5'd7; s.mrd = 32'h1234;
    s.rf1 = 32'h55; s.rf2 = 32'h66;
    applyStimulus(s, 1'b0);
    applyStimulus(s, 1'b0);
    s = base(); s.rs1 = 5'd6; s.rf1 = 32'h55; s.mrd = 32'h9999;
    applyStimulus(s, 1'b0);

    // write x0 with 99, then read x0
    s = base(); s.we = 1'b1; s.rd = 5'd0; s.res = 32'd99;
    applyStimulus(s, 1'b0);
    s = base(); s.rs1 = 5'd0; s.rs2 = 5'd0;
    applyStimulus(s, 1'b0);

    // x8 = 1 then x8 = 2, read x8 with the immediate selected on B
    s = base(); s.we = 1'b1; s.rd = 5'd8; s.res = 32'd1;
    applyStimulus(s, 1'b0);
    s.res = 32'd2;
    applyStimulus(s, 1'b0);
    s = base(); s.rs1 = 5'd8; s.rs2 = 5'd8; s.bsel = 1'b1; s.imm = 32'd16; s.rf1 = 32'd3; s.rf2 = 32'd4;
    applyStimulus(s, 1'b0);

    // load hazard flushed in the same cycle: no stall and no history entry for x10
    s = base(); s.we = 1'b1; s.ld = 1'b1; s.rd = 5'd9;
    applyStimulus(s, 1'b0);
    s = base(); s.rs1 = 5'd9; s.flush = 1'b1; s.we = 1'b1; s.rd = 5'd10; s.res = 32'h77;
    applyStimulus(s, 1'b0);
    s = base(); s.rs1 = 5'd10; s.rf1 = 32'h11;
    applyStimulus(s, 1'b0);

    // reset asserted during a load-use stall
    s = base(); s.we = 1'b1; s.ld = 1'b1; s.rd = 5'd11;
    applyStimulus(s, 1'b0);
    s = base(); s.rs1 = 5'd11; s.rs2 = 5'd11; s.rf1 = 32'hab; s.rf2 = 32'hcd; s.mrd = 32'h42;
    applyStimulus(s, 1'b0);
    s.rst_n = 1'b0;
    applyStimulus(s, 1'b0);
    s.rst_n = 1'b1;
    applyStimulus(s, 1'b1);

    for (int i = 0; i < 400; i++) begin
      s       = base();
      s.valid = ($urandom_range(0, 7) != 0);
      s.flush = ($urandom_range(0, 9) == 0);
      s.rst_n = ($urandom_range(0, 59) != 0);
      s.we    = ($urandom_range(0, 3) != 0);
      s.ld    = ($urandom_range(0, 3) == 0);
      s.asel  = ($urandom_range(0, 4) == 0);
      s.bsel  = ($urandom_range(0, 4) == 0);
      s.rs1   = 5'($urandom_range(0, 7));
      s.rs2   = 5'($urandom_range(0, 7));
      s.rd    = 5'($urandom_range(0, 7));
      s.rf1   = $urandom();
      s.rf2   = $urandom();
      s.pc    = $urandom();
      s.imm   = $urandom();
      s.res   = $urandom();
      s.mrd   = $urandom();
      applyStimulus(s, 1'b0);
    end

    for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain: %0d responses still pending, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
